// File: rtl/serdes_link_if.sv
// rtl/serdes_link_if.sv - deserializer word input and RX FIFO write port bundle
// master: deserializer/FIFO side, slave: link controller side.
interface serdes_link_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_wr_en;
  logic [DATA_W-1:0] rx_wr_data;

  modport master (output rx_data, rx_valid, input rx_wr_en, rx_wr_data);
  modport slave  (input rx_data, rx_valid, output rx_wr_en, rx_wr_data);
endinterface

// File: rtl/serdes_link_ctrl.sv
// rtl/serdes_link_ctrl.sv - LVDS lane reset, bitslip word alignment and RX gating
// Optional LINK_STATS_EN adds slip_total and relock_cnt statistics outputs.
module serdes_link_ctrl #(
  parameter int                DATA_W        = 8,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'h5C,
  parameter int                RST_CYCLES    = 16,
  parameter int                SLIP_WAIT     = 4,
  parameter int                LOCK_MATCHES  = 8,
  parameter int                MAX_SLIPS     = 16
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        train_req,
  input  logic        serdes_ready,
  serdes_link_if.slave rx,
  output logic        serdes_rst,
  output logic        bitslip,
  output logic        link_up,
  output logic        link_fail,
  output logic [7:0]  slip_cnt,
  output logic [2:0]  state
`ifdef LINK_STATS_EN
  ,
  output logic [15:0] slip_total,
  output logic [7:0]  relock_cnt
`endif
);

  localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
  localparam logic [7:0]         SLIP_MAX   = 8'(MAX_SLIPS);

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_WAIT_RDY  = 3'd1,
    ST_COMPARE   = 3'd2,
    ST_SLIP      = 3'd3,
    ST_SLIP_WAIT = 3'd4,
    ST_LINKED    = 3'd5,
    ST_FAIL      = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [7:0]          slip_q, slip_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                ready_lost;

  // FAIL is excluded so a failed attempt stays visible until train_req.
  assign ready_lost = !serdes_ready &&
                      (state_q inside {ST_COMPARE, ST_SLIP, ST_SLIP_WAIT, ST_LINKED});

  always_comb begin
    state_d   = state_q;
    hold_d    = '0;
    wait_d    = '0;
    match_d   = '0;
    slip_d    = slip_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_RST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_WAIT_RDY;
        else                     hold_d  = hold_q + 1'b1;
      end
      ST_WAIT_RDY: begin
        if (serdes_ready) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        match_d = match_q;
        if (rx.rx_valid) begin
          if (rx.rx_data == TRAIN_PATTERN) begin
            if (match_q == MATCH_LAST) begin
              state_d = ST_LINKED;
              match_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
            state_d = (slip_q == SLIP_MAX) ? ST_FAIL : ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        if (slip_q != SLIP_MAX) slip_d = slip_q + 1'b1;
        state_d = ST_SLIP_WAIT;
      end
      ST_SLIP_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_COMPARE;
        else                     wait_d  = wait_q + 1'b1;
      end
      ST_LINKED: begin
        wr_en_d   = rx.rx_valid;
        wr_data_d = rx.rx_data;
      end
      ST_FAIL: ;
      default: state_d = ST_RST_HOLD;
    endcase
    // Exits from LINKED never let the in-flight word reach the FIFO.
    if (ready_lost) begin
      state_d   = ST_RST_HOLD;
      match_d   = '0;
      hold_d    = '0;
      wait_d    = '0;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
    end else if (train_req) begin
      state_d   = ST_WAIT_RDY;
      slip_d    = '0;
      match_d   = '0;
      hold_d    = '0;
      wait_d    = '0;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q   <= ST_RST_HOLD;
      hold_q    <= '0;
      wait_q    <= '0;
      match_q   <= '0;
      slip_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      wait_q    <= wait_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign serdes_rst    = (state_q == ST_RST_HOLD);
  assign bitslip       = (state_q == ST_SLIP);
  assign link_up       = (state_q == ST_LINKED);
  assign link_fail     = (state_q == ST_FAIL);
  assign slip_cnt      = slip_q;
  assign state         = state_q;
  assign rx.rx_wr_en   = wr_en_q;
  assign rx.rx_wr_data = wr_data_q;

`ifdef LINK_STATS_EN
  logic [15:0] slip_total_q;
  logic [7:0]  relock_q;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      slip_total_q <= '0;
      relock_q     <= '0;
    end else begin
      if (state_q == ST_SLIP && slip_total_q != '1) slip_total_q <= slip_total_q + 1'b1;
      if (ready_lost && state_q == ST_LINKED && relock_q != '1) relock_q <= relock_q + 1'b1;
    end
  end

  assign slip_total = slip_total_q;
  assign relock_cnt = relock_q;
`endif

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// tb/tb_serdes_link_ctrl.sv - directed bench with write-port scoreboard for serdes_link_ctrl
module tb_serdes_link_ctrl;

  logic       clk = 1'b0;
  logic       res_n, train_req, serdes_ready;
  logic       serdes_rst, bitslip, link_up, link_fail;
  logic [7:0] slip_cnt;
  logic [2:0] state;
`ifdef LINK_STATS_EN
  logic [15:0] slip_total;
  logic [7:0]  relock_cnt;
`endif

  serdes_link_if #(.DATA_W(8)) lnk ();

  serdes_link_ctrl dut (
    .clk          (clk),
    .res_n        (res_n),
    .train_req    (train_req),
    .serdes_ready (serdes_ready),
    .rx           (lnk),
    .serdes_rst   (serdes_rst),
    .bitslip      (bitslip),
    .link_up      (link_up),
    .link_fail    (link_fail),
    .slip_cnt     (slip_cnt),
    .state        (state)
`ifdef LINK_STATS_EN
    ,
    .slip_total   (slip_total),
    .relock_cnt   (relock_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < (n % 8); i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Lane model: in auto mode each observed bitslip rotates the word left by one.
  logic       lane_auto, vld;
  logic [7:0] man_data, base;
  int         rot;
  assign lnk.rx_data  = lane_auto ? rotl(base, rot) : man_data;
  assign lnk.rx_valid = vld;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0, wr_count = 0;
  int n_slip = 0, last_slip = -1, min_gap = 1000;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (bitslip) begin
      n_slip++;
      rot++;
      if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
      last_slip = cyc;
    end
    if (lnk.rx_wr_en) begin
      exp_t e;
      wr_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected actual=%02h@%0d required=no write", lnk.rx_wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (lnk.rx_wr_data !== e.d || cyc != e.c + 1) begin
          bad++;
          $display("FAIL wr_data actual=%02h@%0d required=%02h@%0d",
                   lnk.rx_wr_data, cyc, e.d, e.c + 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name,
                            output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (state !== s && n < budget);
    if (s == 3'd5) vld = 1'b0;
    chk(name, {29'd0, state}, {29'd0, s});
  endtask

  task automatic count_rst(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (serdes_rst && n < 100);
  endtask

  task automatic clr_slip_stats();
    n_slip = 0;
    last_slip = -1;
    min_gap = 1000;
    rot = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    res_n = 1'b0; train_req = 1'b0; serdes_ready = 1'b1;
    lane_auto = 1'b1; vld = 1'b1; man_data = 8'h00; base = 8'h5C; rot = 0;

    // Reset values
    repeat (3) step();
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_serdes_rst", {31'd0, serdes_rst}, 1);
    chk("rst_bitslip", {31'd0, bitslip}, 0);
    chk("rst_link_up", {31'd0, link_up}, 0);
    chk("rst_link_fail", {31'd0, link_fail}, 0);
    chk("rst_wr_en", {31'd0, lnk.rx_wr_en}, 0);
    chk("rst_wr_data", {24'd0, lnk.rx_wr_data}, 0);
    chk("rst_slip_cnt", {24'd0, slip_cnt}, 0);

    // 1: clean lane locks after 8 matches
    res_n = 1'b1;
    count_rst(n);
    chk("t1_rst_hold_len", n, 16);
    chk("t1_wait_rdy", {29'd0, state}, 1);
    step();
    chk("t1_compare", {29'd0, state}, 2);
    wait_state(3'd5, 40, "t1_link", n);
    chk("t1_lock_cycles", n, 8);
    chk("t1_slip_cnt", {24'd0, slip_cnt}, 0);
    chk("t1_no_bitslip", n_slip, 0);

    // 4: forwarding with alternating valid
    lane_auto = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      man_data = 8'(i);
      vld = (i % 2) == 1;
      if (vld) exp_q.push_back('{d: 8'(i), c: cyc});
      step();
    end
    vld = 1'b0;
    repeat (2) step();
    chk("t4_writes", wr_count, 8);
    chk("t4_link_up", {31'd0, link_up}, 1);

    // 5: one-cycle ready loss while linked, valid word in flight is dropped
    man_data = 8'hAA; vld = 1'b1; serdes_ready = 1'b0;
    step();
    chk("t5_link_up", {31'd0, link_up}, 0);
    chk("t5_wr_en", {31'd0, lnk.rx_wr_en}, 0);
    chk("t5_state", {29'd0, state}, 0);
    serdes_ready = 1'b1; vld = 1'b0;
    count_rst(n);
    chk("t5_rst_hold_len", n, 16);
`ifdef LINK_STATS_EN
    chk("t5_relock_cnt", {24'd0, relock_cnt}, 1);
`endif
    lane_auto = 1'b1; base = 8'h5C; rot = 0; vld = 1'b1;
    wait_state(3'd5, 40, "t5_relink", n);
    chk("t5_relink_cycles", n, 9);

    // 2: lane three rotations off needs three slips
    clr_slip_stats();
    base = 8'h8B; vld = 1'b1; train_req = 1'b1;
    step();
    train_req = 1'b0;
    chk("t2_state_after_req", {29'd0, state}, 1);
    wait_state(3'd5, 200, "t2_link", n);
    chk("t2_lock_cycles", n, 27);
    chk("t2_pulses", n_slip, 3);
    chk("t2_slip_cnt", {24'd0, slip_cnt}, 3);
    chk("t2_gap_ok", {31'd0, min_gap >= 5}, 1);

    // 6: ready loss beats train_req; invalid gaps keep match count
    base = 8'h5C; rot = 0; train_req = 1'b1;
    step();
    train_req = 1'b0;
    step();
    chk("t6_compare", {29'd0, state}, 2);
    lane_auto = 1'b0; man_data = 8'h5C; vld = 1'b1;
    repeat (3) step();
    train_req = 1'b1; serdes_ready = 1'b0;
    step();
    chk("t6_ready_loss_wins", {29'd0, state}, 0);
    train_req = 1'b0; serdes_ready = 1'b1; vld = 1'b0;
    wait_state(3'd2, 60, "t6_recompare", n);
    chk("t6_recompare_cycles", n, 17);
    vld = 1'b1; man_data = 8'h5C;
    repeat (7) step();
    vld = 1'b0; man_data = 8'h00;
    repeat (3) step();
    chk("t6_gap_state", {29'd0, state}, 2);
    chk("t6_gap_link_up", {31'd0, link_up}, 0);
    vld = 1'b1; man_data = 8'h5C;
    step();
    vld = 1'b0;
    chk("t6_link_after_gap", {31'd0, link_up}, 1);

    // 3: stuck lane exhausts slips and fails
    clr_slip_stats();
    lane_auto = 1'b1; base = 8'h00; vld = 1'b1; train_req = 1'b1;
    step();
    train_req = 1'b0;
    wait_state(3'd6, 400, "t3_fail", n);
    chk("t3_fail_cycles", n, 98);
    chk("t3_pulses", n_slip, 16);
    chk("t3_slip_cnt", {24'd0, slip_cnt}, 16);
    chk("t3_link_fail", {31'd0, link_fail}, 1);
    chk("t3_gap_ok", {31'd0, min_gap >= 5}, 1);
    repeat (4) step();
    chk("t3_fail_held", {29'd0, state}, 6);
`ifdef LINK_STATS_EN
    chk("t3_slip_total", {16'd0, slip_total}, 19);
`endif
    vld = 1'b0; train_req = 1'b1;
    step();
    train_req = 1'b0;
    chk("t3_fail_cleared", {31'd0, link_fail}, 0);
    chk("t3_state_after_req", {29'd0, state}, 1);
    chk("t3_slip_cnt_cleared", {24'd0, slip_cnt}, 0);

    repeat (2) step();
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
